histogram_accum: RTL and testbench
==================================

Name: histogram_accum

Overview:
- Pixel-rate histogram accumulator that drives the 512x32 true-dual-port histogram RAM.
- Port A has READ_BEFORE_WRITE behaviour, no output register and 1-cycle read latency. Port B is NORMAL_WRITE.
- Each accepted pixel costs one read on port A and one write on port B. A 3-stage pipeline forwards in-flight counts to avoid read-modify-write hazards.
- At frame end the block sweeps the bins over port A, reading and zero-clearing each bin in the same cycle. It streams the counts to the downstream statistics/CDF stage.

Parameters:
- PIX_WIDTH, 8, pixel/bin index width; NUM_BINS = 2^PIX_WIDTH, and PIX_WIDTH must be <= ADDR_WIDTH.
- ADDR_WIDTH, 9, RAM address width; upper ADDR_WIDTH-PIX_WIDTH address bits are driven 0.
- DATA_WIDTH, 32, bin count width.

Ports:
- clk, in, 1, single clock; also drives RAM a_clk/b_clk.
- rst, in, 1, asynchronous active-high reset.
- pix_data, in, PIX_WIDTH, pixel value = bin index.
- pix_valid, in, 1, pixel qualifier.
- frame_end, in, 1, single-cycle pulse: last pixel of frame delivered.
- ram_a_addr, out, ADDR_WIDTH, RAM port A address.
- ram_a_wr_data, out, DATA_WIDTH, RAM port A write data; always 0.
- ram_a_wr_en, out, 1, RAM port A write enable (clear).
- ram_a_rd_data, in, DATA_WIDTH, RAM port A read data; valid 1 cycle after address.
- ram_b_addr, out, ADDR_WIDTH, RAM port B address.
- ram_b_wr_data, out, DATA_WIDTH, RAM port B write data.
- ram_b_wr_en, out, 1, RAM port B write enable.
- hist_valid, out, 1, histogram output beat.
- hist_bin, out, PIX_WIDTH, bin index of the beat.
- hist_count, out, DATA_WIDTH, bin count; 0 when hist_valid=0.
- hist_last, out, 1, marks bin NUM_BINS-1.
- busy, out, 1, high in CLEAR/DRAIN/DUMP; pixels are not accepted.
- pix_drop, out, 1, 1-cycle pulse when pix_valid arrives while busy.

Behaviour:
- Reset values: all outputs 0, pipeline valids 0, state=CLEAR, sweep counter=0.
- FSM states: CLEAR, ACCUM, DRAIN, DUMP.
- CLEAR:
  - Sweeps addresses 0..NUM_BINS-1, one per cycle, with ram_a_wr_en=1 and data 0. No hist output.
  - After bin NUM_BINS-1 -> ACCUM. Duration is exactly NUM_BINS cycles after rst deasserts.
- ACCUM, pixel pipeline:
  - S0 (cycle t): pix_valid -> ram_a_addr=pix_data (read only); s1_vld/s1_addr registered.
  - S1 (t+1): base is chosen by priority:
    - s2_data, if s2_vld and s2_addr==s1_addr;
    - else s3_data, if s3_vld and s3_addr==s1_addr;
    - else ram_a_rd_data.
  - S1 update: s2_data <= base+1, saturating at 2^DATA_WIDTH-1 (no wrap).
  - S2 (t+2): ram_b_wr_en=s2_vld, ram_b_addr=s2_addr, ram_b_wr_data=s2_data; the write commits at the t+2 edge.
  - S3 (t+3): copy of the committed S2 entry, held only for forwarding.
  - Result: back-to-back identical pixels produce 1,2,3... with no lost increments. Throughput is 1 pixel/cycle.
- frame_end in ACCUM -> DRAIN. A pixel valid in the same cycle as frame_end is accepted.
  - DRAIN lasts exactly 2 cycles so the last write commits before the first dump read.
  - Then -> DUMP.
- DUMP:
  - Cycle d+k: ram_a_addr=k, ram_a_wr_en=1, data 0. Read-before-write returns the old count.
  - Cycle d+k+1: hist_valid=1, hist_bin=k, hist_count=ram_a_rd_data, hist_last=(k==NUM_BINS-1).
  - After issuing k=NUM_BINS-1 -> ACCUM. The final output beat appears in the first ACCUM cycle; S0 may accept pixels that cycle.
- No backpressure: downstream must accept one beat per cycle.
- Ignored inputs:
  - pix_valid while busy is dropped and pulses pix_drop.
  - frame_end outside ACCUM is ignored.
  - frame_end with no pixels in the frame still performs DUMP, giving all-zero counts.
- ram_b_wr_en=0 outside S2 activity. Port A and port B never address the same bin in the same cycle with a write.
- Reset mid-operation: pipeline flushes, partial counts are discarded, and CLEAR reruns.

Test Plan:
- Release rst -> busy=1 for exactly 256 cycles, ram_a_wr_en=1 with addr 0..255; then busy=0.
- 10 consecutive pixels all =7, then frame_end -> DUMP: bin 7 count=10, all other bins 0, hist_last only on bin 255, 256 beats.
- Pattern 3,3,5,3,5,5 back-to-back (exercises S2 and S3 forwarding) -> bin 3=3, bin 5=3.
- Second frame after dump with a single pixel 0 -> bin 0=1 and former bin 7 =0, proving the read-and-clear.
- pix_valid asserted during DUMP -> pix_drop pulses; those pixels are absent from the next frame's counts.
- Preload bin 9 = 0xFFFFFFFF via a bench RAM backdoor, then feed 2 pixels of 9 -> dump count stays 0xFFFFFFFF.
- Assert rst during DUMP at bin 100 -> hist_valid=0 immediately; CLEAR reruns for 256 cycles, and the next frame dump shows only new pixels.

Source files
------------

// File: rtl/histogram_accum.sv
// Pixel-rate histogram accumulator driving a true-dual-port RAM: read on port A, increment
// through a forwarding pipeline, write on port B; read-and-clear sweep of all bins at frame end.
module histogram_accum #(
    parameter int unsigned PIX_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PIX_WIDTH-1:0]  pix_data,
    input  logic                  pix_valid,
    input  logic                  frame_end,
    output logic [ADDR_WIDTH-1:0] ram_a_addr,
    output logic [DATA_WIDTH-1:0] ram_a_wr_data,
    output logic                  ram_a_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_a_rd_data,
    output logic [ADDR_WIDTH-1:0] ram_b_addr,
    output logic [DATA_WIDTH-1:0] ram_b_wr_data,
    output logic                  ram_b_wr_en,
    output logic                  hist_valid,
    output logic [PIX_WIDTH-1:0]  hist_bin,
    output logic [DATA_WIDTH-1:0] hist_count,
    output logic                  hist_last,
    output logic                  busy,
    output logic                  pix_drop
);

    typedef enum logic [1:0] {StClear, StAccum, StDrain, StDump} state_e;

    state_e                state_q, state_d;
    logic [PIX_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  s1_vld_q, s1_vld_d;
    logic [PIX_WIDTH-1:0]  s1_addr_q, s1_addr_d;
    logic                  s2_vld_q, s2_vld_d;
    logic [PIX_WIDTH-1:0]  s2_addr_q, s2_addr_d;
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic                  s3_vld_q, s3_vld_d;
    logic [PIX_WIDTH-1:0]  s3_addr_q, s3_addr_d;
    logic [DATA_WIDTH-1:0] s3_data_q, s3_data_d;
    logic                  out_vld_q, out_vld_d;
    logic [PIX_WIDTH-1:0]  out_bin_q, out_bin_d;

    logic [PIX_WIDTH-1:0]  a_addr;
    logic                  a_wr_en;
    logic                  accept;
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH:0]   sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StClear;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_addr_q <= '0;
            s2_data_q <= '0;
            s3_vld_q  <= 1'b0;
            s3_addr_q <= '0;
            s3_data_q <= '0;
            out_vld_q <= 1'b0;
            out_bin_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_addr_q <= s1_addr_d;
            s2_vld_q  <= s2_vld_d;
            s2_addr_q <= s2_addr_d;
            s2_data_q <= s2_data_d;
            s3_vld_q  <= s3_vld_d;
            s3_addr_q <= s3_addr_d;
            s3_data_q <= s3_data_d;
            out_vld_q <= out_vld_d;
            out_bin_q <= out_bin_d;
        end
    end

    // Sweep/accumulate control; cnt_q is the bin sweep index in CLEAR/DUMP and the DRAIN timer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_addr    = pix_data;
        a_wr_en   = 1'b0;
        accept    = 1'b0;
        out_vld_d = 1'b0;
        out_bin_d = cnt_q;
        unique case (state_q)
            StClear: begin
                a_addr  = cnt_q;
                a_wr_en = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                accept = pix_valid;
                if (frame_end) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q[0]) begin
                    state_d = StDump;
                    cnt_d   = '0;
                end
            end
            StDump: begin
                a_addr    = cnt_q;
                a_wr_en   = 1'b1;
                out_vld_d = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = StAccum;
                end
            end
            default: ;
        endcase
    end

    // The RAM read lags two writes: S2 commits on the same edge as our read (old data returned),
    // S3 committed on that edge. Forward the youngest matching in-flight count.
    always_comb begin
        base = ram_a_rd_data;
        if (s2_vld_q && (s2_addr_q == s1_addr_q)) begin
            base = s2_data_q;
        end else if (s3_vld_q && (s3_addr_q == s1_addr_q)) begin
            base = s3_data_q;
        end
        sum       = {1'b0, base} + {{DATA_WIDTH{1'b0}}, 1'b1};
        s2_data_d = sum[DATA_WIDTH] ? base : sum[DATA_WIDTH-1:0];

        s1_vld_d  = accept;
        s1_addr_d = pix_data;
        s2_vld_d  = s1_vld_q;
        s2_addr_d = s1_addr_q;
        s3_vld_d  = s2_vld_q;
        s3_addr_d = s2_addr_q;
        s3_data_d = s2_data_q;
    end

    assign ram_a_wr_data = '0;

    // Outputs are forced low while reset is asserted, including the comb RAM controls.
    always_comb begin
        ram_a_addr    = '0;
        ram_a_wr_en   = 1'b0;
        ram_b_addr    = '0;
        ram_b_wr_data = '0;
        ram_b_wr_en   = 1'b0;
        hist_valid    = 1'b0;
        hist_bin      = '0;
        hist_count    = '0;
        hist_last     = 1'b0;
        busy          = 1'b0;
        pix_drop      = 1'b0;
        if (!rst) begin
            ram_a_addr    = ADDR_WIDTH'(a_addr);
            ram_a_wr_en   = a_wr_en;
            ram_b_addr    = ADDR_WIDTH'(s2_addr_q);
            ram_b_wr_data = s2_data_q;
            ram_b_wr_en   = s2_vld_q;
            busy          = (state_q != StAccum);
            pix_drop      = pix_valid && (state_q != StAccum);
            hist_valid    = out_vld_q;
            hist_bin      = out_bin_q;
            hist_count    = out_vld_q ? ram_a_rd_data : '0;
            hist_last     = out_vld_q && (&out_bin_q);
        end
    end

endmodule

// File: tb/tb_histogram_accum.sv
// Bench for histogram_accum: behavioural RAM with read-before-write port A, plain-array bin
// counter reference model, randomized and directed frames.
module tb_histogram_accum;

    localparam int PW = 8;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int NB = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          frame_end = 1'b0;
    logic [AW-1:0] ram_a_addr;
    logic [DW-1:0] ram_a_wr_data;
    logic          ram_a_wr_en;
    logic [DW-1:0] a_rd = '0;
    logic [AW-1:0] ram_b_addr;
    logic [DW-1:0] ram_b_wr_data;
    logic          ram_b_wr_en;
    logic          hist_valid;
    logic [PW-1:0] hist_bin;
    logic [DW-1:0] hist_count;
    logic          hist_last;
    logic          busy;
    logic          pix_drop;

    logic [DW-1:0] mem [2**AW];
    logic          bd_en = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ref_cnt  [NB];
    logic [DW-1:0] exp_dump [NB];
    logic [DW-1:0] got_count[NB];
    int beats, last_hits, last_bin, order_bad, zero_viol;

    histogram_accum #(.PIX_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid), .frame_end(frame_end),
        .ram_a_addr(ram_a_addr), .ram_a_wr_data(ram_a_wr_data), .ram_a_wr_en(ram_a_wr_en),
        .ram_a_rd_data(a_rd), .ram_b_addr(ram_b_addr), .ram_b_wr_data(ram_b_wr_data),
        .ram_b_wr_en(ram_b_wr_en), .hist_valid(hist_valid), .hist_bin(hist_bin),
        .hist_count(hist_count), .hist_last(hist_last), .busy(busy), .pix_drop(pix_drop)
    );

    always #5 clk = ~clk;

    // RAM: port A read-before-write with 1-cycle latency, port B write, plus a backdoor port.
    always @(posedge clk) begin
        a_rd <= mem[ram_a_addr];
        if (ram_a_wr_en) mem[ram_a_addr] <= ram_a_wr_data;
        if (ram_b_wr_en) mem[ram_b_addr] <= ram_b_wr_data;
        if (bd_en) mem[bd_addr] <= bd_data;
    end

    // Beat collector only; tests judge the collected data.
    always @(negedge clk) begin
        if (hist_valid) begin
            got_count[hist_bin] = hist_count;
            if (int'(hist_bin) != beats) order_bad++;
            if (hist_last) begin
                last_hits++;
                last_bin = int'(hist_bin);
            end
            beats++;
        end else if (hist_count != '0) begin
            zero_viol++;
        end
    end

    task automatic clear_capture();
        beats = 0; last_hits = 0; last_bin = -1; order_bad = 0; zero_viol = 0;
        for (int b = 0; b < NB; b++) got_count[b] = 'x;
    endtask

    task automatic drive(input logic v, input logic [PW-1:0] d, input logic fe);
        @(posedge clk);
        #1;
        pix_valid = v; pix_data = d; frame_end = fe;
    endtask

    // Pixel the DUT is expected to accept: the model counts it, saturating.
    task automatic feed(input logic [PW-1:0] d, input logic fe);
        drive(1'b1, d, fe);
        if (ref_cnt[d] != '1) ref_cnt[d] = ref_cnt[d] + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0);
    endtask

    // Wait for a full dump; the model's bins move to exp_dump and are cleared (read-and-clear).
    task automatic wait_dump(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (beats >= NB) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        for (int b = 0; b < NB; b++) begin
            exp_dump[b] = ref_cnt[b];
            ref_cnt[b]  = '0;
        end
    endtask

    function automatic int bad_bins(output int first);
        int n = 0;
        first = 0;
        for (int b = 0; b < NB; b++) begin
            if (got_count[b] !== exp_dump[b]) begin
                if (n == 0) first = b;
                n++;
            end
        end
        return n;
    endfunction

    task automatic test_reset();
        int bad;
        bad = 0;
        @(negedge clk);
        checks++;
        if ({busy, ram_a_wr_en, ram_b_wr_en, hist_valid, hist_last, pix_drop, hist_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b a_we=%b b_we=%b hv=%b cnt=%h required all 0",
                     busy, ram_a_wr_en, ram_b_wr_en, hist_valid, hist_count);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || ram_a_wr_en !== 1'b1 || ram_a_addr !== AW'(i) ||
                ram_a_wr_data !== '0 || ram_b_wr_en !== 1'b0 || hist_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_sweep: %0d bad cycles, required 0", bad);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ram_a_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL clear_end: busy=%b a_we=%b required 0 0", busy, ram_a_wr_en);
        end
    endtask

    task automatic test_same_pixel();
        bit ok;
        int nb, fb;
        clear_capture();
        for (int i = 0; i < 9; i++) feed(8'd7, 1'b0);
        feed(8'd7, 1'b1);
        idle(1);
        wait_dump(ok);
        checks++;
        if (!ok || beats != NB) begin
            errors++;
            $display("FAIL same_beats: got %0d beats required %0d", beats, NB);
        end
        checks++;
        if (got_count[7] !== 32'd10) begin
            errors++;
            $display("FAIL same_bin7: got %h required %h", got_count[7], 32'd10);
        end
        nb = bad_bins(fb);
        checks++;
        if (nb != 0) begin
            errors++;
            $display("FAIL same_counts: %0d bins wrong, bin %0d got %h required %h",
                     nb, fb, got_count[fb], exp_dump[fb]);
        end
        checks++;
        if (last_hits != 1 || last_bin != NB - 1 || order_bad != 0) begin
            errors++;
            $display("FAIL same_last: last_hits=%0d last_bin=%0d order_bad=%0d required 1 255 0",
                     last_hits, last_bin, order_bad);
        end
        checks++;
        if (zero_viol != 0) begin
            errors++;
            $display("FAIL same_idle_count: %0d nonzero counts without valid, required 0", zero_viol);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int nb, fb;
        logic [PW-1:0] pat [6];
        pat = '{8'd3, 8'd3, 8'd5, 8'd3, 8'd5, 8'd5};
        clear_capture();
        for (int i = 0; i < 6; i++) feed(pat[i], (i == 5));
        idle(1);
        wait_dump(ok);
        checks++;
        if (!ok || got_count[3] !== 32'd3 || got_count[5] !== 32'd3) begin
            errors++;
            $display("FAIL b2b_bins: bin3=%h bin5=%h required 3 3", got_count[3], got_count[5]);
        end
        nb = bad_bins(fb);
        checks++;
        if (nb != 0) begin
            errors++;
            $display("FAIL b2b_counts: %0d bins wrong, bin %0d got %h required %h",
                     nb, fb, got_count[fb], exp_dump[fb]);
        end
    endtask

    task automatic test_read_clear();
        bit ok;
        clear_capture();
        feed(8'd0, 1'b1);
        idle(1);
        wait_dump(ok);
        checks++;
        if (!ok || got_count[0] !== 32'd1 || got_count[7] !== 32'd0 || got_count[3] !== 32'd0) begin
            errors++;
            $display("FAIL read_clear: bin0=%h bin7=%h bin3=%h required 1 0 0",
                     got_count[0], got_count[7], got_count[3]);
        end
    endtask

    task automatic test_drop();
        bit ok;
        int drops, nb, fb;
        drops = 0;
        clear_capture();
        feed(8'd2, 1'b0);
        feed(8'd4, 1'b1);
        idle(5);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'd4, 1'b0);
            @(negedge clk);
            if (pix_drop === 1'b1) drops++;
        end
        drive(1'b0, '0, 1'b1);
        idle(1);
        wait_dump(ok);
        checks++;
        if (drops != 5) begin
            errors++;
            $display("FAIL drop_pulses: got %0d required 5", drops);
        end
        nb = bad_bins(fb);
        checks++;
        if (!ok || nb != 0) begin
            errors++;
            $display("FAIL drop_frame: %0d bins wrong, bin %0d got %h required %h",
                     nb, fb, got_count[fb], exp_dump[fb]);
        end
        idle(3);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_fe_ignored: busy=%b required 0", busy);
        end
        clear_capture();
        feed(8'd9, 1'b1);
        idle(1);
        wait_dump(ok);
        checks++;
        if (!ok || got_count[4] !== 32'd0 || got_count[9] !== 32'd1) begin
            errors++;
            $display("FAIL drop_next: bin4=%h bin9=%h required 0 1", got_count[4], got_count[9]);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        @(posedge clk);
        #1;
        bd_en = 1'b1; bd_addr = AW'(9); bd_data = '1;
        @(posedge clk);
        #1 bd_en = 1'b0;
        ref_cnt[9] = '1;
        clear_capture();
        feed(8'd9, 1'b0);
        feed(8'd9, 1'b1);
        idle(1);
        wait_dump(ok);
        checks++;
        if (!ok || got_count[9] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL saturate: got %h required ffffffff", got_count[9]);
        end
    endtask

    task automatic test_random();
        bit ok;
        int nb, fb;
        logic [PW-1:0] d;
        for (int f = 0; f < 2; f++) begin
            clear_capture();
            for (int i = 0; i < 400; i++) begin
                d = ($urandom % 2 == 0) ? PW'($urandom_range(0, 7)) : PW'($urandom_range(0, 255));
                if (i == 399) feed(d, 1'b1);
                else if ($urandom % 4 != 0) feed(d, 1'b0);
                else drive(1'b0, d, 1'b0);
            end
            idle(1);
            wait_dump(ok);
            nb = bad_bins(fb);
            checks++;
            if (!ok || nb != 0) begin
                errors++;
                $display("FAIL random_frame%0d: %0d bins wrong, bin %0d got %h required %h",
                         f, nb, fb, got_count[fb], exp_dump[fb]);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        bit ok, hit;
        int nb, fb, busy_cyc;
        clear_capture();
        for (int i = 0; i < 50; i++) feed(PW'($urandom_range(0, 255)), (i == 49));
        idle(1);
        hit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (hist_valid === 1'b1 && hist_bin === 8'd100) begin
                hit = 1'b1;
                break;
            end
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (!hit || hist_valid !== 1'b0 || hist_count !== '0) begin
            errors++;
            $display("FAIL rst_mid_dump: reached=%b hv=%b cnt=%h required 1 0 0",
                     hit, hist_valid, hist_count);
        end
        for (int b = 0; b < NB; b++) ref_cnt[b] = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        busy_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            busy_cyc++;
        end
        checks++;
        if (busy_cyc != NB) begin
            errors++;
            $display("FAIL rst_clear_len: busy %0d cycles required %0d", busy_cyc, NB);
        end
        clear_capture();
        for (int i = 0; i < 30; i++) feed(PW'($urandom_range(0, 255)), (i == 29));
        idle(1);
        wait_dump(ok);
        nb = bad_bins(fb);
        checks++;
        if (!ok || nb != 0) begin
            errors++;
            $display("FAIL rst_next_frame: %0d bins wrong, bin %0d got %h required %h",
                     nb, fb, got_count[fb], exp_dump[fb]);
        end
    endtask

    initial begin
        for (int b = 0; b < NB; b++) ref_cnt[b] = '0;
        clear_capture();
        test_reset();
        test_same_pixel();
        test_back_to_back();
        test_read_clear();
        test_drop();
        test_saturate();
        test_random();
        test_reset_mid_dump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
